// File: rtl/bsg_tiehi_checker_pkg.sv
// Shared types and helpers for the tie-high bus checker.
package bsg_tiehi_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter must hold values 0..debounce inclusive.
    function automatic int unsigned debounce_cnt_width(input int unsigned debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/bsg_tiehi_debounce.sv
// One-bit debounce counter with a sticky fault flag; confirm_o pulses on the
// edge at which the flag is about to be set.
module bsg_tiehi_debounce
    import bsg_tiehi_checker_pkg::*;
#(
    parameter int unsigned debounce_p = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    input  logic clear_i,
    input  logic data_i,
    output logic confirm_o,
    output logic fault_o
);

    localparam int unsigned CW = debounce_cnt_width(debounce_p);
    localparam logic [CW-1:0] LIMIT = CW'(debounce_p);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_fault;

    always_comb begin
        w_cnt_nxt = '0;
        if (en_i && !data_i) begin
            w_cnt_nxt = (r_cnt == LIMIT) ? r_cnt : r_cnt + 1'b1;
        end
    end

    assign confirm_o = en_i && !clear_i && !r_fault && (w_cnt_nxt == LIMIT);
    assign fault_o   = r_fault;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else if (clear_i) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (confirm_o) begin
                r_fault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_tiehi_checker.sv
// Tie-high bus checker: per-bit debounce, sticky fault mask, first-fault report
// over valid/ready, saturating event count. Define BSG_TIEHI_CHECKER_SYNC_EN to
// add a two-flop input synchronizer.
module bsg_tiehi_checker
    import bsg_tiehi_checker_pkg::*;
#(
    parameter int unsigned width_p       = 128,
    parameter int unsigned debounce_p    = 4,
    parameter int unsigned count_width_p = 16,
    localparam int unsigned idx_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    input  logic [width_p-1:0]       data_i,
    input  logic                     clear_i,
    output logic                     err_o,
    output logic [width_p-1:0]       fault_mask_o,
    output logic [count_width_p-1:0] fault_count_o,
    output logic                     v_o,
    output logic [idx_width_lp-1:0]  first_idx_o,
    input  logic                     ready_i
);

    logic [width_p-1:0]       w_data;
    logic [width_p-1:0]       w_confirm;
    logic [width_p-1:0]       w_mask;
    logic                     w_any;
    logic [idx_width_lp-1:0]  w_first;

    state_e                   r_state;
    logic                     r_v;
    logic                     r_err;
    logic [idx_width_lp-1:0]  r_idx;
    logic [count_width_p-1:0] r_count;

`ifdef BSG_TIEHI_CHECKER_SYNC_EN
    logic [width_p-1:0] r_sync1;
    logic [width_p-1:0] r_sync2;

    // Reset to all-ones so a fresh reset never looks like a fault.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= data_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_data = r_sync2;
`else
    assign w_data = data_i;
`endif

    for (genvar g = 0; g < width_p; g++) begin : g_bit
        bsg_tiehi_debounce #(
            .debounce_p(debounce_p)
        ) u_deb (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .en_i     (en_i),
            .clear_i  (clear_i),
            .data_i   (w_data[g]),
            .confirm_o(w_confirm[g]),
            .fault_o  (w_mask[g])
        );
    end

    assign w_any = |w_confirm;

    always_comb begin
        w_first = '0;
        for (int unsigned i = width_p; i > 0; i--) begin
            if (w_confirm[i-1]) begin
                w_first = idx_width_lp'(i - 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_v     <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_v     <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            if (w_any) begin
                r_err <= 1'b1;
                if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (en_i) begin
                case (r_state)
                    IDLE: begin
                        if (w_any) begin
                            r_state <= REPORT;
                            r_v     <= 1'b1;
                            r_idx   <= w_first;
                        end
                    end
                    REPORT: begin
                        if (ready_i) begin
                            r_state <= DONE;
                            r_v     <= 1'b0;
                        end
                    end
                    DONE: begin
                        r_v <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_v     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign err_o         = r_err;
    assign fault_mask_o  = w_mask;
    assign fault_count_o = r_count;
    assign v_o           = r_v;
    assign first_idx_o   = r_idx;

endmodule

// File: tb/tb_bsg_tiehi_checker.sv
// Directed, table-driven bench for bsg_tiehi_checker (width 128, debounce 4).
module tb_bsg_tiehi_checker;

    localparam int W    = 128;
    localparam int D    = 4;
    localparam int CWID = 16;
`ifdef BSG_TIEHI_CHECKER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int E = D + SYNC_LAT;

    logic            clk;
    logic            reset_n;
    logic            en;
    logic [W-1:0]    data;
    logic            clear;
    logic            ready;
    logic            err;
    logic [W-1:0]    mask;
    logic [CWID-1:0] count;
    logic            v;
    logic [6:0]      idx;

    int checks   = 0;
    int failures = 0;

    bsg_tiehi_checker #(
        .width_p      (W),
        .debounce_p   (D),
        .count_width_p(CWID)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .en_i         (en),
        .data_i       (data),
        .clear_i      (clear),
        .err_o        (err),
        .fault_mask_o (mask),
        .fault_count_o(count),
        .v_o          (v),
        .first_idx_o  (idx),
        .ready_i      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    data;
        logic            en;
        logic            clear;
        logic            ready;
        int              n;
        bit              settle;
        logic            err;
        logic            v;
        logic [CWID-1:0] cnt;
        logic [6:0]      idx;
        logic [W-1:0]    mask;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [W-1:0] bm(input int b);
        logic [W-1:0] m;
        m    = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] d, input logic e, input logic c,
                                input logic r, input int n, input bit s, input logic xe,
                                input logic xv, input logic [CWID-1:0] xc,
                                input logic [6:0] xi, input logic [W-1:0] xm);
        vec_t t;
        t.data = d; t.en = e; t.clear = c; t.ready = r; t.n = n; t.settle = s;
        t.err = xe; t.v = xv; t.cnt = xc; t.idx = xi; t.mask = xm;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic xe, input logic xv,
                             input logic [CWID-1:0] xc, input logic [6:0] xi,
                             input logic [W-1:0] xm);
        chk({tag, "_err"},   err,   xe);
        chk({tag, "_v"},     v,     xv);
        chk({tag, "_count"}, count, xc);
        chk({tag, "_idx"},   idx,   xi);
        chk({tag, "_mask"},  mask,  xm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] m5_90;
        logic [W-1:0] m5_90_100;
        ones      = '1;
        m5_90     = bm(5) | bm(90);
        m5_90_100 = m5_90 | bm(100);

        //               data          en    clr   rdy   n    settle err   v     cnt  idx  mask
        tbl[0]  = mk(ones,            1'b1, 1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        tbl[1]  = mk(~bm(37),         1'b1, 1'b0, 1'b0, 3,   1'b0, 1'b0, 1'b0, 0, 0, '0);
        tbl[2]  = mk(ones,            1'b1, 1'b0, 1'b0, 5,   1'b0, 1'b0, 1'b0, 0, 0, '0);
        tbl[3]  = mk(~m5_90,          1'b1, 1'b0, 1'b0, 4,   1'b1, 1'b1, 1'b1, 1, 5, m5_90);
        tbl[4]  = mk(ones,            1'b1, 1'b0, 1'b0, 10,  1'b0, 1'b1, 1'b1, 1, 5, m5_90);
        tbl[5]  = mk(ones,            1'b1, 1'b0, 1'b1, 1,   1'b0, 1'b1, 1'b0, 1, 5, m5_90);
        tbl[6]  = mk(ones,            1'b1, 1'b0, 1'b0, 1,   1'b0, 1'b1, 1'b0, 1, 5, m5_90);
        tbl[7]  = mk(~bm(100),        1'b1, 1'b0, 1'b0, 4,   1'b1, 1'b1, 1'b0, 2, 5, m5_90_100);
        tbl[8]  = mk(ones,            1'b1, 1'b1, 1'b0, 1,   1'b0, 1'b0, 1'b0, 0, 0, '0);
        tbl[9]  = mk(ones,            1'b1, 1'b0, 1'b0, 3,   1'b0, 1'b0, 1'b0, 0, 0, '0);
        tbl[10] = mk(~bm(7),          1'b0, 1'b0, 1'b0, 8,   1'b0, 1'b0, 1'b0, 0, 0, '0);
        tbl[11] = mk(~bm(7),          1'b1, 1'b0, 1'b0, 4,   1'b1, 1'b1, 1'b1, 1, 7, bm(7));

        data    = '1;
        en      = 1'b1;
        clear   = 1'b0;
        ready   = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check_all("reset", 1'b0, 1'b0, 0, 0, '0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            data  = tbl[i].data;
            en    = tbl[i].en;
            clear = tbl[i].clear;
            ready = tbl[i].ready;
            repeat (tbl[i].n + (tbl[i].settle ? SYNC_LAT : 0)) tick();
            check_all($sformatf("vec%0d", i), tbl[i].err, tbl[i].v, tbl[i].cnt,
                      tbl[i].idx, tbl[i].mask);
        end

        // Exact confirmation latency, with ready already high when v rises.
        en = 1'b1; ready = 1'b0; data = '1; clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        data  = ~bm(20);
        for (int k = 1; k <= E; k++) begin
            tick();
            chk($sformatf("lat_mask_k%0d", k), mask, (k == E) ? bm(20) : '0);
            chk($sformatf("lat_v_k%0d", k), v, (k == E));
        end
        chk("lat_idx", idx, 20);
        chk("lat_count", count, 1);
        tick();
        chk("lat_v_after_hs", v, 0);

        // Clear wins over a simultaneous confirmation and ready.
        ready = 1'b0; data = '1; clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        data = ~bm(3);
        repeat (E - 1) tick();
        chk("clr_pre_mask", mask, '0);
        clear = 1'b1;
        ready = 1'b1;
        tick();
        clear = 1'b0;
        ready = 1'b0;
        check_all("clr_same", 1'b0, 1'b0, 0, 0, '0);
        repeat (D - 1) tick();
        chk("clr_idle_pre_mask", mask, '0);
        tick();
        check_all("clr_idle_rep", 1'b1, 1'b1, 1, 3, bm(3));

        // Async reset mid-debounce clears everything without a clock edge.
        data = ~bm(60);
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 0, 0, '0);
        data = '1;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_all("post_rst", 1'b0, 1'b0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_tiehi_checker.md
# bsg_tiehi_checker

Monitors a bus that a `bsg_tiehi` instance drives and that must stay all-ones. It debounces each bit and latches any bit that reads low long enough as a sticky fault. It reports the first fault through a valid/ready handshake and keeps a saturating fault-event count. It sits at the receiving end of tie-off nets, for example across a hard-macro boundary or in bring-up test logic, and checks that the constant arrives intact.

## Interface
- `width_p`, default 128: number of monitored bits.
- `debounce_p`, default 4: consecutive low samples needed to confirm a fault. Must be at least 1.
- `count_width_p`, default 16: width of the fault-event counter.
- `clk_i`  in  1: the single clock.
- `reset_n_i`  in  1: reset, asynchronous, active-low.
- `en_i`  in  1: enables checking.
- `data_i`  in  `width_p`: the bus under check. Every bit is expected to be 1.
- `clear_i`  in  1: synchronous clear of all sticky state.
- `err_o`  out  1: sticky; high when any bit is confirmed faulty.
- `fault_mask_o`  out  `width_p`: sticky per-bit fault flags.
- `fault_count_o`  out  `count_width_p`: saturating count of fault events.
- `v_o`  out  1: a first-fault report is valid.
- `first_idx_o`  out  `$clog2(width_p)`: index of the first confirmed fault. Held stable while `v_o` is high.
- `ready_i`  in  1: the consumer accepts the report.

## Operation
- Reset values: `err_o`=0, `fault_mask_o`=0, `fault_count_o`=0, `v_o`=0, `first_idx_o`=0. All debounce counters are 0 and the FSM is in IDLE.
- Per-bit debounce counter:
  - Counts clock edges at which `en_i`=1 and the bit is 0.
  - Returns to 0 on any edge where the bit is 1 or `en_i`=0.
  - Saturates at `debounce_p`.
- Confirmation:
  - A bit confirms at the edge where its counter reaches `debounce_p` and its mask bit is still 0.
  - That edge sets the mask bit.
  - A set mask bit stays set even if the input returns high.
- `err_o` equals the OR-reduction of the registered `fault_mask_o`.
- `fault_count_o` increments by 1 on each edge with at least one new confirmation, regardless of how many bits confirm. It saturates at all-ones.
- FSM:
  - IDLE → REPORT on the first edge with a new confirmation. That edge latches the lowest newly confirmed index into `first_idx_o`.
  - REPORT: `v_o`=1. The handshake fires on the edge where `v_o` and `ready_i` are both high, and the FSM moves to DONE.
  - DONE: `v_o`=0. Later faults update only the mask and the count. No further report is issued.
- `clear_i`=1:
  - On that edge it zeroes the mask, the count, all debounce counters and `first_idx_o`, and forces the FSM to IDLE.
  - It overrides any confirmation or handshake in the same cycle.
  - It is the only way `v_o` can drop without a handshake.
- `en_i`=0: sticky state and the FSM hold. No new confirmations occur.
- Asserting reset mid-operation returns everything to reset values immediately, without waiting for a clock edge.

## Timing
- Without sync: a bit first sampled low at edge N, and held low, confirms at edge N+`debounce_p`−1. `fault_mask_o`, `err_o`, `v_o` and `fault_count_o` update after that edge.
- A glitch shorter than `debounce_p` samples never confirms.
- `v_o` is registered and does not depend combinationally on `ready_i`.
- If `ready_i` is already high when `v_o` rises, the handshake completes on the next edge.
- With `debounce_p`=1, a single low sample confirms.
- All outputs are registered.

## Configuration
- `BSG_TIEHI_CHECKER_SYNC_EN` defined: `data_i` passes through a two-flop synchronizer before the debounce counters. Confirmation latency grows by 2 edges. The synchronizer flops reset to all-ones.
- Undefined: `data_i` feeds the debounce counters directly. Use this only for synchronous sources.

## Structure
- Package `bsg_tiehi_checker_pkg` holds:
  - the FSM state enum: IDLE, REPORT, DONE;
  - a function computing the debounce-counter width, `$clog2(debounce_p+1)`.
- Sub-module `bsg_tiehi_debounce`: a one-bit debounce counter plus sticky flag, instantiated `width_p` times.
- The top level contains the lowest-index priority encoder, the event counter and the FSM.

## Test plan
- Hold `data_i` all-ones for 100 cycles with `en_i`=1 → `err_o`=0, `v_o`=0, `fault_count_o`=0.
- Drive bit 37 low for 3 cycles with `debounce_p`=4 → no confirmation; the mask stays 0.
- Drive bits 90 and 5 low together for 4 cycles → both mask bits set on the same edge, `first_idx_o`=5, `fault_count_o`=1, `v_o`=1. Hold `ready_i`=0 for 10 cycles → `v_o` and `first_idx_o` stay stable. Then pulse `ready_i` → `v_o`=0 on the next cycle.
- After a report, drive bit 100 low for 4 cycles → `fault_mask_o[100]`=1, `fault_count_o`=2, `v_o` stays 0.
- Assert `clear_i` in the same cycle as a new confirmation and `ready_i` → mask=0, count=0, FSM in IDLE, `v_o`=0. Separately, assert `reset_n_i`=0 mid-debounce → all outputs 0 immediately.
- With `BSG_TIEHI_CHECKER_SYNC_EN` defined, a bit that goes low confirms 2 edges later than without the macro.
